// File: rtl/mem_dump_reader_pkg.sv
// Shared definitions for the debug memory dump reader.
// DATA_WIDTH is the pipeline data-memory word width.
package mem_dump_reader_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int DUMP_BYTES_PER_WORD = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    DUMP_IDLE   = 3'd0,
    DUMP_READ   = 3'd1,
    DUMP_WAIT   = 3'd2,
    DUMP_SEND   = 3'd3,
    DUMP_FINISH = 3'd4,
    DUMP_CSUM   = 3'd5
  } dump_state_e;

  function automatic int idx_width(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/mem_dump_reader_word_serializer.sv
// Word-to-byte serializer, MSB first, on a valid/ready stream.
// last_o pulses on the handshake of the final byte of a load.
module mem_dump_reader_word_serializer
  import mem_dump_reader_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              load_one_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              tx_ready_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  output logic              last_o
);

  localparam int BPW = DATA_W / 8;
  localparam int IW  = idx_width(BPW);

  logic [DATA_W-1:0] shift_q;
  logic [IW-1:0]     byte_idx_q;
  logic              valid_q;
  logic              hs;

  assign hs         = valid_q & tx_ready_i;
  assign last_o     = hs && (byte_idx_q == IW'(BPW - 1));
  assign tx_data_o  = shift_q[DATA_W-1 -: 8];
  assign tx_valid_o = valid_q;

  // A single-byte load starts at the last index so one handshake ends it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q    <= '0;
      byte_idx_q <= '0;
      valid_q    <= 1'b0;
    end else if (load_i) begin
      shift_q    <= load_data_i;
      byte_idx_q <= load_one_i ? IW'(BPW - 1) : '0;
      valid_q    <= 1'b1;
    end else if (hs) begin
      shift_q    <= shift_q << 8;
      byte_idx_q <= last_o ? '0 : byte_idx_q + 1'b1;
      valid_q    <= ~last_o;
    end
  end

endmodule

// File: rtl/mem_dump_reader.sv
// Debug dump of a word range of data memory as a byte stream.
// Optional trailing XOR byte: define MEM_DUMP_CHECKSUM_EN.
module mem_dump_reader
  import mem_dump_reader_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = DATA_WIDTH,
  parameter int READ_LAT = 1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_word_i,
  input  logic [ADDR_W:0]   word_count_i,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  dump_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W:0]   rem_q;
  logic [1:0]        wait_q;
  logic              rd_en_q;
  logic              busy_q;
  logic              done_q;

  logic              load;
  logic              load_one;
  logic [DATA_W-1:0] load_data;
  logic              last;
  logic              wait_last;
  logic              last_word;

  assign wait_last = (state_q == DUMP_WAIT) &&
                     (wait_q == 2'(READ_LAT - 1));
  assign last_word = (rem_q == (ADDR_W+1)'(1));

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [7:0] csum_q;
  logic [7:0] csum_d;
  logic [7:0] csum_byte;
  logic       csum_load;

  assign csum_d = (state_q == DUMP_SEND && tx_valid_o && tx_ready_i) ?
                  csum_q ^ tx_data_o : csum_q;
  assign csum_load =
    (state_q == DUMP_IDLE && start_i && word_count_i == '0) ||
    (state_q == DUMP_SEND && last && last_word);
  // An empty dump still emits a checksum, and csum_q may be stale then
  assign csum_byte = (state_q == DUMP_IDLE) ? 8'h00 : csum_d;
  assign load      = wait_last | csum_load;
  assign load_one  = csum_load;
  assign load_data = csum_load ?
                     (DATA_W'(csum_byte) << (DATA_W - 8)) :
                     mem_rd_data_i;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      csum_q <= '0;
    end else if (state_q == DUMP_IDLE && start_i) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`else
  assign load      = wait_last;
  assign load_one  = 1'b0;
  assign load_data = mem_rd_data_i;
`endif

  mem_dump_reader_word_serializer #(
    .DATA_W (DATA_W)
  ) u_ser (
    .clk_i       (clk_i),
    .rst_ni      (reset_ni),
    .load_i      (load),
    .load_one_i  (load_one),
    .load_data_i (load_data),
    .tx_ready_i  (tx_ready_i),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .last_o      (last)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= DUMP_IDLE;
      addr_q    <= '0;
      rd_addr_q <= '0;
      rem_q     <= '0;
      wait_q    <= '0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        DUMP_IDLE: begin
          if (start_i) begin
            addr_q <= base_word_i;
            rem_q  <= word_count_i;
            busy_q <= 1'b1;
            if (word_count_i == '0) begin
`ifdef MEM_DUMP_CHECKSUM_EN
              state_q <= DUMP_CSUM;
`else
              state_q <= DUMP_FINISH;
              done_q  <= 1'b1;
`endif
            end else begin
              state_q   <= DUMP_READ;
              rd_en_q   <= 1'b1;
              rd_addr_q <= base_word_i;
            end
          end
        end
        DUMP_READ: begin
          wait_q  <= '0;
          state_q <= DUMP_WAIT;
        end
        DUMP_WAIT: begin
          if (wait_last) state_q <= DUMP_SEND;
          else wait_q <= wait_q + 1'b1;
        end
        DUMP_SEND: begin
          if (last) begin
            rem_q  <= rem_q - 1'b1;
            addr_q <= addr_q + 1'b1;
            if (!last_word) begin
              state_q   <= DUMP_READ;
              rd_en_q   <= 1'b1;
              rd_addr_q <= addr_q + 1'b1;
            end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
              state_q <= DUMP_CSUM;
`else
              state_q <= DUMP_FINISH;
              done_q  <= 1'b1;
`endif
            end
          end
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        DUMP_CSUM: begin
          if (last) begin
            state_q <= DUMP_FINISH;
            done_q  <= 1'b1;
          end
        end
`endif
        DUMP_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= DUMP_IDLE;
        end
        default: state_q <= DUMP_IDLE;
      endcase
    end
  end

  assign mem_rd_en_o   = rd_en_q;
  assign mem_rd_addr_o = rd_addr_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Randomized scoreboard bench for mem_dump_reader.
// Covers wrap, empty dump, stalls, mid-dump reset, checksum.
module tb_mem_dump_reader;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int BPW = DW / 8;
`ifdef MEM_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   count = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          busy;
  logic          done;

  mem_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut (
    .clk_i         (clk),
    .reset_ni      (rst_n),
    .start_i       (start),
    .base_word_i   (base),
    .word_count_i  (count),
    .mem_rd_en_o   (rd_en),
    .mem_rd_addr_o (rd_addr),
    .mem_rd_data_i (rd_data),
    .tx_data_o     (tx_data),
    .tx_valid_o    (tx_valid),
    .tx_ready_i    (tx_ready),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [256];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int addr_q[$];
  int ready_mode = 0;
  logic pat[$];
  int hs_cnt, first_hs, last_hs, done_cyc, start_cyc;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = (tx_valid && pat.size() > 0) ?
                          pat.pop_front() : 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        chk("hold_valid", 32'(tx_valid), 32'd1);
        chk("hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_byte: got %0h expected none", tx_data);
        end else chk("byte", 32'(tx_data), 32'(exp_q.pop_front()));
        if (hs_cnt == 0) first_hs = cyc;
        last_hs = cyc;
        hs_cnt++;
      end
      if (rd_en) begin
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_read: got %0d expected none", rd_addr);
        end else chk("rd_addr", 32'(rd_addr), 32'(addr_q.pop_front()));
      end
      if (done) done_cyc = cyc;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else prev_stall = 1'b0;
  end

  // Reference: words from the range, bytes MSB first, then optional XOR
  task automatic expect_dump(input int b, input int c);
    logic [DW-1:0] w;
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < c; i++) begin
      addr_q.push_back((b + i) % 256);
      w = mem[(b + i) % 256];
      for (int k = BPW - 1; k >= 0; k--) begin
        exp_q.push_back(w[8*k +: 8]);
        x = x ^ w[8*k +: 8];
      end
    end
    if (CS == 1) exp_q.push_back(x);
  endtask

  task automatic issue(input int b, input int c, input int mode);
    hs_cnt = 0; done_cyc = -1;
    ready_mode = mode;
    expect_dump(b, c);
    @(posedge clk); #2;
    start = 1'b1; base = AW'(b); count = (AW+1)'(c);
    start_cyc = cyc;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done_cyc < 0 && n < budget) begin
      @(negedge clk); #1; n++;
    end
    chk({name, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
    @(negedge clk); #1;
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
    chk({name, "_busy_low"}, 32'(busy), 32'd0);
    chk({name, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_reads_left"}, 32'(addr_q.size()), 32'd0);
  endtask

  task automatic dump(input string name, input int b, input int c,
                      input int mode);
    issue(b, c, mode);
    wait_done(name, 64 + c * 40);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({name, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({name, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({name, "_tx_valid"}, 32'(tx_valid), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    #12;
    chk_idle_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    mem[10] = 32'h11223344;
    dump("single", 10, 1, 0);
    chk("single_first_lat", 32'(first_hs - start_cyc), 32'd3);
    chk("single_consec", 32'(last_hs - first_hs), 32'(BPW + CS - 1));
    chk("single_done_lat", 32'(done_cyc - last_hs), 32'd1);

    mem[254] = 32'hA; mem[255] = 32'hB; mem[0] = 32'hC;
    dump("wrap", 254, 3, 0);
    chk("wrap_nbytes", 32'(hs_cnt), 32'(3 * BPW + CS));

    dump("empty", 77, 0, 0);
    chk("empty_nbytes", 32'(hs_cnt), 32'(CS));
    if (CS == 0) begin
      chk("empty_done_lat_lo", 32'(done_cyc - start_cyc >= 1), 32'd1);
      chk("empty_done_lat_hi", 32'(done_cyc - start_cyc <= 2), 32'd1);
    end

    mem[20] = 32'hDEADBEEF;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    dump("stall", 20, 1, 2);

    issue(40, 4, 0);
    n = 0;
    while (hs_cnt < BPW + 2 && n < 200) begin
      @(negedge clk); n++;
    end
    chk("abort_reached_word2", 32'(hs_cnt >= BPW + 2), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_idle_outputs("abort");
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(posedge clk);
    #1 chk("abort_no_done", 32'(done_cyc), 32'hFFFFFFFF);
    @(negedge clk); rst_n = 1'b1;
    dump("after_abort", 5, 1, 0);

`ifdef MEM_DUMP_CHECKSUM_EN
    mem[30] = 32'h01020304; mem[31] = 32'hFF000000;
    dump("csum", 30, 2, 0);
`endif

    for (int t = 0; t < 10; t++)
      dump("rand", int'($urandom_range(0, 255)),
           int'($urandom_range(0, 5)), 1);

    dump("full", int'($urandom_range(0, 255)), 256, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
